alu_core: RTL and testbench



---
 rtl/alu_core.sv | 107 ++++++++++
 tb/tb_alu_core.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Registered N-bit ALU producing a result and NZCV flags every clock; the stored C flag feeds
// ADC/SBC. Define ALU_MUL_EN to build the multiplier for opcode 0010 (otherwise it is reserved).
module alu_core #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   s,
    output logic [N-1:0] z,
    output logic [3:0]   flags
);

    typedef enum logic [3:0] {
        OpAdd = 4'h0,
        OpSub = 4'h1,
        OpMul = 4'h2,
        OpSbc = 4'h3,
        OpSll = 4'h4,
        OpSrl = 4'h5,
        OpSra = 4'h6,
        OpRor = 4'h7,
        OpAnd = 4'h8,
        OpOr  = 4'h9,
        OpXor = 4'hA,
        OpMvn = 4'hB,
        OpAdc = 4'hC,
        OpMov = 4'hD,
        OpBic = 4'hE,
        OpRsv = 4'hF
    } op_e;

    localparam logic [N-1:0] WidthN = N[N-1:0];

    op_e          op;
    logic         c_reg;
    logic         is_sub;
    logic         cin;
    logic [N-1:0] addend;
    logic [N:0]   sum;
    logic         v_arith;
    logic [N-1:0] rot_amt;
    logic [N-1:0] rot;
    logic [N-1:0] r;
    logic         c_d;
    logic         v_d;

    assign op    = op_e'(s);
    assign c_reg = flags[1];

    // Subtraction is a + ~b + cin, so C comes out as "no borrow" for free.
    always_comb begin
        is_sub  = (op == OpSub) || (op == OpSbc);
        addend  = is_sub ? ~b : b;
        cin     = 1'b0;
        if (op == OpSub) begin
            cin = 1'b1;
        end else if ((op == OpAdc) || (op == OpSbc)) begin
            cin = c_reg;
        end
        sum     = {1'b0, a} + {1'b0, addend} + {{N{1'b0}}, cin};
        v_arith = (a[N-1] == addend[N-1]) && (sum[N-1] != a[N-1]);
        rot_amt = b % WidthN;
        rot     = (a >> rot_amt) | (a << (WidthN - rot_amt));
    end

    always_comb begin
        r   = '0;
        c_d = 1'b0;
        v_d = 1'b0;
        unique case (op)
            OpAdd, OpSub, OpSbc, OpAdc: begin
                r   = sum[N-1:0];
                c_d = sum[N];
                v_d = v_arith;
            end
`ifdef ALU_MUL_EN
            OpMul: r = a * b;
`else
            OpMul: r = '0;
`endif
            OpSll: r = a << b;
            OpSrl: r = a >> b;
            OpSra: r = $signed(a) >>> b;
            OpRor: r = rot;
            OpAnd: r = a & b;
            OpOr:  r = a | b;
            OpXor: r = a ^ b;
            OpMvn: r = ~a;
            OpMov: r = b;
            OpBic: r = a & ~b;
            OpRsv: r = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z     <= '0;
            flags <= 4'b0000;
        end else begin
            z     <= r;
            flags <= {r[N-1], ~|r, c_d, v_d};
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: directed vectors with fixed expectations, then random traffic
// checked against an integer-arithmetic reference model.
module tb_alu_core;

    localparam int N = 3;
    localparam int M = 1 << N;
    localparam int H = 1 << (N - 1);

    logic         clk;
    logic         rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   s;
    logic [N-1:0] z;
    logic [3:0]   flags;

    alu_core #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .s     (s),
        .z     (z),
        .flags (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [N-1:0] ez;
        logic [3:0]   ef;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   model_c = 1'b0;
    bit   done = 1'b0;

    // Reference model: plain integer arithmetic on the opcode definitions.
    task automatic model(input int ua, input int ub, input int op,
                         output logic [N-1:0] rz, output logic [3:0] rf);
        int  sa, sb, full, sres, res, k;
        bit  c, v;
        sa = (ua >= H) ? ua - M : ua;
        sb = (ub >= H) ? ub - M : ub;
        c = 0; v = 0; res = 0; full = 0; sres = 0;
        case (op)
            0, 12: begin
                full = ua + ub + ((op == 12) ? int'(model_c) : 0);
                sres = sa + sb + ((op == 12) ? int'(model_c) : 0);
                c = (full >= M);
                v = (sres > H - 1) || (sres < -H);
            end
            1, 3: begin
                full = ua - ub - ((op == 3) ? 1 - int'(model_c) : 0);
                sres = sa - sb - ((op == 3) ? 1 - int'(model_c) : 0);
                c = (full >= 0);
                v = (sres > H - 1) || (sres < -H);
            end
            default: ;
        endcase
        case (op)
            0, 1, 3, 12: res = ((full % M) + M) % M;
`ifdef ALU_MUL_EN
            2:  res = (ua * ub) % M;
`else
            2:  res = 0;
`endif
            4:  res = (ub >= N) ? 0 : (ua << ub) % M;
            5:  res = (ub >= N) ? 0 : ua >> ub;
            6:  res = (ub >= N) ? ((sa < 0) ? M - 1 : 0) : (((sa >>> ub) % M) + M) % M;
            7: begin
                k   = ub % N;
                res = (ua >> k) + ((ua << (N - k)) % M);
            end
            8:  res = ua & ub;
            9:  res = ua | ub;
            10: res = ua ^ ub;
            11: res = M - 1 - ua;
            13: res = ub;
            14: res = ua & ~ub & (M - 1);
            default: res = 0;
        endcase
        model_c = c;
        rz = res[N-1:0];
        rf = {res >= H, res == 0, c, v};
    endtask

    // Drive one cycle at the falling edge; directed vectors supply their own expectation.
    task automatic drive(input bit r, input int ua, input int ub, input int op, input string name,
                         input bit use_fixed, input logic [N-1:0] fz, input logic [3:0] ff);
        exp_t         e;
        logic [N-1:0] mz;
        logic [3:0]   mf;
        @(negedge clk);
        rst = r;
        a   = ua[N-1:0];
        b   = ub[N-1:0];
        s   = op[3:0];
        if (r) begin
            model_c = 1'b0;
            mz = '0;
            mf = 4'b0000;
        end else begin
            model(ua, ub, op, mz, mf);
        end
        e.name = name;
        e.ez   = use_fixed ? fz : mz;
        e.ef   = use_fixed ? ff : mf;
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a new result every edge, one per queued stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (z !== e.ez) begin
                    errors++;
                    $display("FAIL %s z: got %b expected %b", e.name, z, e.ez);
                end
                checks++;
                if (flags !== e.ef) begin
                    errors++;
                    $display("FAIL %s flags: got %b expected %b", e.name, flags, e.ef);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        s   = '0;
        drive(1, 7, 7, 0,  "reset",       1, 3'b000, 4'b0000);
        drive(0, 1, 1, 12, "adc_after_rst", 1, 3'b010, 4'b0000);
        drive(0, 1, 1, 0,  "add_1_1",     1, 3'b010, 4'b0000);
        drive(0, 1, 1, 1,  "sub_1_1",     1, 3'b000, 4'b0110);
        drive(0, 3, 1, 0,  "add_ovf",     1, 3'b100, 4'b1001);
        drive(0, 7, 1, 0,  "add_wrap",    1, 3'b000, 4'b0110);
        drive(0, 1, 1, 12, "adc_carry",   1, 3'b011, 4'b0000);
        drive(0, 1, 2, 4,  "sll",         1, 3'b100, 4'b1000);
        drive(0, 1, 1, 5,  "srl",         1, 3'b000, 4'b0100);
        drive(0, 4, 1, 6,  "sra",         1, 3'b110, 4'b1000);
        drive(0, 1, 3, 4,  "sll_big",     1, 3'b000, 4'b0100);
        drive(0, 4, 5, 6,  "sra_big",     1, 3'b111, 4'b1000);
        drive(0, 1, 1, 7,  "ror",         1, 3'b100, 4'b1000);
        drive(0, 1, 1, 8,  "and",         1, 3'b001, 4'b0000);
        drive(0, 1, 1, 10, "xor",         1, 3'b000, 4'b0100);
        drive(0, 1, 1, 12, "adc_nocarry", 1, 3'b010, 4'b0000);
        drive(0, 1, 1, 3,  "sbc_borrow",  1, 3'b111, 4'b1000);
`ifdef ALU_MUL_EN
        drive(0, 2, 3, 2,  "mul",         1, 3'b110, 4'b1000);
`else
        drive(0, 2, 3, 2,  "mul_rsv",     1, 3'b000, 4'b0100);
`endif
        drive(0, 5, 6, 15, "reserved",    1, 3'b000, 4'b0100);
        drive(0, 0, 0, 11, "mvn",         1, 3'b111, 4'b1000);
        drive(0, 3, 1, 14, "bic",         1, 3'b010, 4'b0000);
        drive(0, 7, 1, 0,  "add_set_c",   1, 3'b000, 4'b0110);
        drive(1, 5, 5, 12, "mid_reset",   1, 3'b000, 4'b0000);
        drive(0, 1, 1, 12, "adc_post_rst", 1, 3'b010, 4'b0000);

        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 31) == 0), $urandom_range(0, M - 1),
                  $urandom_range(0, M - 1), $urandom_range(0, 15), "random", 0, '0, '0);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
